if_id_decode_stage: RTL and testbench

//  Downstream neighbour of the fetch stage: IF/ID pipeline buffer plus MIPS-32 instruction decode.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mips_control_decoder.sv | 87 ++++++++
 rtl/if_id_decode_stage.sv | 114 +++++++++++
 tb/tb_if_id_decode_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-32 widths, opcode values and ALU operation classes
package mips_pkg;

  localparam int XLEN = 32;

  // Primary opcode field instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation class handed to execute; FUNCT means "look at instr[5:0]"
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_FUNCT = 3'd5
  } alu_op_e;

  // 16-bit immediate to full datapath width, sign-extended
  function automatic logic [XLEN-1:0] sign_extend16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_control_decoder.sv
// rtl/mips_control_decoder.sv - combinational opcode to control-signal decode
module mips_control_decoder (
  input  logic        valid,
  input  logic [31:0] instr,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  alu_op,
  output logic        illegal
);
  import mips_pkg::*;

  logic [5:0] opcode;
  assign opcode = instr[31:26];

  // Control lines stay quiet for an empty slot so execute never sees stale side effects
  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          // the all-zero word is the canonical NOP (sll $0,$0,0): no register update
          reg_write = (instr != 32'h0);
          reg_dst   = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          reg_write  = 1'b1;
          alu_src    = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          alu_op     = ALU_ADD;
        end
        OP_SW: begin
          alu_src   = 1'b1;
          mem_write = 1'b1;
          alu_op    = ALU_ADD;
        end
        OP_BEQ: begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
        OP_ADDI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALU_ADD;
        end
        OP_ANDI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALU_AND;
        end
        OP_ORI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALU_OR;
        end
        OP_SLTI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALU_SLT;
        end
        OP_J: begin
          jump = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_decode_stage.sv
// rtl/if_id_decode_stage.sv - IF/ID two-entry skid buffer with MIPS-32 field split, control decode and targets
module if_id_decode_stage #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] PC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc4,
  input  logic [XLEN-1:0] if_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc4,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_funct,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_br_target,
  output logic [XLEN-1:0] id_j_target,
  output logic            id_reg_write,
  output logic            id_reg_dst,
  output logic            id_alu_src,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_mem_to_reg,
  output logic            id_branch,
  output logic            id_jump,
  output logic [2:0]      id_alu_op,
  output logic            id_illegal
);
  import mips_pkg::*;

  // Main entry M feeds decode; skid entry S catches the word that arrives while M stalls
  logic            m_valid;
  logic [XLEN-1:0] m_pc4;
  logic [XLEN-1:0] m_instr;
  logic            s_valid;
  logic [XLEN-1:0] s_pc4;
  logic [XLEN-1:0] s_instr;

  logic in_xfer;
  logic out_xfer;

  // Ready is a pure function of registered state, so fetch never sees a combinational path from execute
  assign if_ready = ~s_valid;
  assign id_valid = m_valid;
  assign in_xfer  = if_valid & if_ready;
  assign out_xfer = m_valid & id_ready;

  // Buffer update: flush wins, otherwise refill M from S first, else from fetch; overflow goes to S
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pc4   <= PC_RST;
      m_instr <= '0;
      s_valid <= 1'b0;
      s_pc4   <= PC_RST;
      s_instr <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_xfer) begin
      if (s_valid) begin
        // if_ready is low while S is full, so no fresh word can arrive here
        m_valid <= 1'b1;
        m_pc4   <= s_pc4;
        m_instr <= s_instr;
        s_valid <= 1'b0;
      end else begin
        m_valid <= in_xfer;
        if (in_xfer) begin
          m_pc4   <= if_pc4;
          m_instr <= if_instr;
        end
      end
    end else if (in_xfer) begin
      s_valid <= 1'b1;
      s_pc4   <= if_pc4;
      s_instr <= if_instr;
    end
  end

  assign id_pc4   = m_pc4;
  assign id_rs    = m_instr[25:21];
  assign id_rt    = m_instr[20:16];
  assign id_rd    = m_instr[15:11];
  assign id_shamt = m_instr[10:6];
  assign id_funct = m_instr[5:0];
  assign id_imm   = sign_extend16(m_instr[15:0]);

  // Word offset scaled to bytes; the sum wraps modulo 2^XLEN with no overflow reporting
  assign id_br_target = m_pc4 + {id_imm[XLEN-3:0], 2'b00};
  assign id_j_target  = {m_pc4[XLEN-1:XLEN-4], m_instr[25:0], 2'b00};

  mips_control_decoder u_ctrl (
    .valid      (m_valid),
    .instr      (m_instr),
    .reg_write  (id_reg_write),
    .reg_dst    (id_reg_dst),
    .alu_src    (id_alu_src),
    .mem_read   (id_mem_read),
    .mem_write  (id_mem_write),
    .mem_to_reg (id_mem_to_reg),
    .branch     (id_branch),
    .jump       (id_jump),
    .alu_op     (id_alu_op),
    .illegal    (id_illegal)
  );

endmodule

// File: tb/tb_if_id_decode_stage.sv
// tb/tb_if_id_decode_stage.sv - randomized scoreboard bench for the IF/ID decode stage
module tb_if_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic [31:0] id_imm, id_br_target, id_j_target;
  logic        id_reg_write, id_reg_dst, id_alu_src, id_mem_read;
  logic        id_mem_write, id_mem_to_reg, id_branch, id_jump;
  logic [2:0]  id_alu_op;
  logic        id_illegal;

  always #5 clk = ~clk;

  if_id_decode_stage #(.XLEN(32), .PC_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc4(if_pc4), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_imm(id_imm), .id_br_target(id_br_target), .id_j_target(id_j_target),
    .id_reg_write(id_reg_write), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op), .id_illegal(id_illegal)
  );

  typedef struct {
    logic [31:0] pc4, imm, br, jt;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        rw, rdst, asrc, mr, mw, m2r, br_en, jmp, ill;
    logic [2:0]  alu;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: instruction semantics straight from the MIPS field layout and opcode table
  function automatic exp_t ref_decode(input logic [31:0] pc4, input logic [31:0] ins);
    exp_t e;
    e.pc4 = pc4;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11];
    e.shamt = ins[10:6]; e.funct = ins[5:0];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.br  = pc4 + e.imm * 32'd4;
    e.jt  = {pc4[31:28], ins[25:0], 2'b00};
    {e.rw, e.rdst, e.asrc, e.mr, e.mw, e.m2r, e.br_en, e.jmp, e.ill} = '0;
    e.alu = 3'd0;
    case (ins[31:26])
      6'h00: begin e.rw = (ins != 0); e.rdst = 1; e.alu = 3'd5; end
      6'h23: begin e.rw = 1; e.asrc = 1; e.mr = 1; e.m2r = 1; end
      6'h2B: begin e.asrc = 1; e.mw = 1; end
      6'h04: begin e.br_en = 1; e.alu = 3'd1; end
      6'h08: begin e.rw = 1; e.asrc = 1; e.alu = 3'd0; end
      6'h0C: begin e.rw = 1; e.asrc = 1; e.alu = 3'd2; end
      6'h0D: begin e.rw = 1; e.asrc = 1; e.alu = 3'd3; end
      6'h0A: begin e.rw = 1; e.asrc = 1; e.alu = 3'd4; end
      6'h02: begin e.jmp = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Monitor: between edges, the front of the model queue must be what the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("id_valid", id_valid, q.size() > 0);
        chk("if_ready", if_ready, q.size() < 2);
        if (q.size() > 0) begin
          e = q[0];
          chk("pc4", id_pc4, e.pc4);
          chk("rs", id_rs, e.rs); chk("rt", id_rt, e.rt); chk("rd", id_rd, e.rd);
          chk("shamt", id_shamt, e.shamt); chk("funct", id_funct, e.funct);
          chk("imm", id_imm, e.imm); chk("br_target", id_br_target, e.br);
          chk("j_target", id_j_target, e.jt);
          chk("ctrl", {id_reg_write, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
                       id_mem_to_reg, id_branch, id_jump, id_illegal},
                      {e.rw, e.rdst, e.asrc, e.mr, e.mw, e.m2r, e.br_en, e.jmp, e.ill});
          chk("alu_op", id_alu_op, e.alu);
          if (id_ready) void'(q.pop_front());
        end else begin
          chk("idle_ctrl", {id_reg_write, id_reg_dst, id_alu_src, id_mem_read, id_mem_write,
                            id_mem_to_reg, id_branch, id_jump, id_illegal, id_alu_op}, 0);
        end
      end
    end
  end

  // One fetch/execute cycle: drive at negedge, model the handshake, update the scoreboard
  task automatic step(input logic iv, input logic [31:0] pc4, input logic [31:0] ins,
                      input logic rdy, input logic fl, output logic acc);
    @(negedge clk);
    if_valid = iv; if_pc4 = pc4; if_instr = ins; id_ready = rdy; flush = fl;
    #1;
    acc = iv && !fl && (q.size() < 2);
    #2;
    if (fl) q.delete();
    else if (acc) q.push_back(ref_decode(pc4, ins));
  endtask

  logic [5:0] ops [10];
  logic       acc;
  logic [31:0] cur_pc4, cur_ins, r;
  logic        have;
  int          tries;

  initial begin
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    rst_n = 1'b0; flush = 0; if_valid = 0; if_pc4 = 0; if_instr = 0; id_ready = 0;
    #2;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_ctrl", {id_reg_write, id_alu_src, id_mem_read, id_branch, id_jump, id_illegal, id_alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $2,4($1)
    step(1, 32'h04, 32'h8C220004, 1, 0, acc);
    #3;
    chk("lw_rs", id_rs, 1); chk("lw_rt", id_rt, 2); chk("lw_imm", id_imm, 4);
    chk("lw_mem_read", id_mem_read, 1); chk("lw_alu_src", id_alu_src, 1);
    step(0, 0, 0, 1, 0, acc);

    // beq back by one word, and a jump
    step(1, 32'h10, 32'h1000FFFF, 1, 0, acc);
    #3;
    chk("beq_target", id_br_target, 32'h0C); chk("beq_branch", id_branch, 1);
    chk("beq_alu", id_alu_op, 3'd1);
    step(1, 32'h40, 32'h08000010, 1, 0, acc);
    #3;
    chk("j_target", id_j_target, 32'h40); chk("j_jump", id_jump, 1);

    // wrap of the branch adder
    step(1, 32'hFFFFFFFC, 32'h10000001, 1, 0, acc);
    #3;
    chk("br_wrap", id_br_target, 32'h0);

    // illegal opcode still flows, then NOP
    step(1, 32'h44, 32'hFC000000, 1, 0, acc);
    #3;
    chk("ill_flag", id_illegal, 1); chk("ill_valid", id_valid, 1);
    step(1, 32'h48, 32'h00000000, 1, 0, acc);
    #3;
    chk("nop_rw", id_reg_write, 0); chk("nop_ill", id_illegal, 0);
    step(0, 0, 0, 1, 0, acc);

    // backpressure: three offered, two taken, third held by fetch until room
    step(1, 32'h100, 32'h20010001, 0, 0, acc);
    step(1, 32'h104, 32'h20020002, 0, 0, acc);
    step(1, 32'h108, 32'h20030003, 0, 0, acc);
    #3;
    chk("bp_if_ready", if_ready, 0);
    tries = 0;
    do begin
      step(1, 32'h108, 32'h20030003, 1, 0, acc);
      tries++;
    end while (!acc && tries < 10);
    chk("bp_third_taken", tries < 10, 1);
    repeat (4) step(0, 0, 0, 1, 0, acc);

    // flush with S full and a word on the fetch side
    step(1, 32'h200, 32'h34040004, 0, 0, acc);
    step(1, 32'h204, 32'h34050005, 0, 0, acc);
    step(1, 32'h208, 32'hDEADBEEF, 0, 1, acc);
    #3;
    chk("flush_id_valid", id_valid, 0); chk("flush_if_ready", if_ready, 1);
    repeat (2) step(0, 0, 0, 1, 0, acc);

    // asynchronous reset with both entries held
    step(1, 32'h300, 32'h8C000000, 0, 0, acc);
    step(1, 32'h304, 32'hAC000000, 0, 0, acc);
    #1;
    rst_n = 1'b0; if_valid = 0; q.delete();
    #1;
    chk("arst_id_valid", id_valid, 0); chk("arst_if_ready", if_ready, 1);
    chk("arst_ctrl", {id_mem_read, id_mem_write, id_alu_src, id_reg_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic; fetch holds an offered word until it is taken or flushed
    have = 0;
    for (int c = 0; c < 800; c++) begin
      logic fl, iv, rdy;
      if (!have) begin
        r = $urandom();
        cur_ins = ($urandom_range(0, 15) == 0) ? 32'h0 : {ops[$urandom_range(0, 9)], r[25:0]};
        if ($urandom_range(0, 9) == 0) cur_ins = $urandom();
        cur_pc4 = {$urandom()} & 32'hFFFFFFFC;
        have = 1;
      end
      iv  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 19) == 0);
      step(iv, cur_pc4, cur_ins, rdy, fl, acc);
      if (acc || (fl && iv)) have = 0;
    end
    repeat (4) step(0, 0, 0, 1, 0, acc);
    chk("drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
